// File: rtl/debug_frame_collector.sv
// rtl/debug_frame_collector.sv - debug frame requester, frame FIFO and MSB-first byte serializer
module debug_frame_collector #(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int NB_SELECT        = 6,
    parameter int FIFO_DEPTH       = 8,
    parameter int NB_TIMEOUT       = 10,
    parameter int TIMEOUT          = 512
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_cmd_valid,
    input  logic [NB_SELECT-1:0]        i_cmd_id,
    output logic [NB_SELECT-1:0]        o_request_select,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame,
    input  logic                        i_writing,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready,
    output logic                        o_busy,
    output logic [7:0]                  o_frame_count,
    output logic                        o_overflow,
    output logic                        o_timeout
);
    localparam int NB_BYTES = NB_CONTROL_FRAME / 8;
    localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int NB_PTR   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE, DRAIN} state_t;

    state_t                      state;
    logic [NB_CONTROL_FRAME-1:0] mem [FIFO_DEPTH];
    logic [NB_PTR:0]             wr_ptr;
    logic [NB_PTR:0]             rd_ptr;
    logic [NB_TIMEOUT-1:0]       timeout_count;
    logic [NB_CONTROL_FRAME-1:0] ser_frame;
    logic [NB_IDX-1:0]           ser_idx;
    logic                        ser_valid;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        tx_accept;
    logic                        last_byte;
    logic                        pop;
    logic                        push_req;
    logic                        push;
    logic                        drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[NB_PTR] != rd_ptr[NB_PTR]) &&
                        (wr_ptr[NB_PTR-1:0] == rd_ptr[NB_PTR-1:0]);
    assign tx_accept  = ser_valid && i_tx_ready;
    assign last_byte  = (ser_idx == NB_IDX'(NB_BYTES - 1));
    // Reloading on the last accepted byte keeps the byte stream bubble-free.
    assign pop        = !fifo_empty && (!ser_valid || (tx_accept && last_byte));
    assign push_req   = i_writing && ((state == REQUEST) || (state == RECEIVE));
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push;

    assign o_tx_valid = ser_valid;
    assign o_tx_data  = ser_frame[NB_CONTROL_FRAME-1 -: 8];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state            <= IDLE;
            o_request_select <= '0;
            o_busy           <= 1'b0;
            o_frame_count    <= '0;
            o_overflow       <= 1'b0;
            o_timeout        <= 1'b0;
            timeout_count    <= '0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cmd_valid && (i_cmd_id != '0)) begin
                        state            <= REQUEST;
                        o_request_select <= i_cmd_id;
                        o_busy           <= 1'b1;
                        o_frame_count    <= '0;
                        o_overflow       <= 1'b0;
                        timeout_count    <= '0;
                    end
                end
                REQUEST: begin
                    timeout_count <= timeout_count + 1'b1;
                    if (i_writing) begin
                        state <= RECEIVE;
                    end else if (timeout_count == NB_TIMEOUT'(TIMEOUT - 1)) begin
                        state            <= IDLE;
                        o_request_select <= '0;
                        o_busy           <= 1'b0;
                        o_timeout        <= 1'b1;
                    end
                end
                RECEIVE: begin
                    if (!i_writing) begin
                        state            <= DRAIN;
                        o_request_select <= '0;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !ser_valid) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (push && (o_frame_count != 8'hFF)) begin
                o_frame_count <= o_frame_count + 8'd1;
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr[NB_PTR-1:0]] <= i_frame;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ser_frame <= '0;
            ser_idx   <= '0;
            ser_valid <= 1'b0;
        end else if (pop) begin
            ser_frame <= mem[rd_ptr[NB_PTR-1:0]];
            ser_idx   <= '0;
            ser_valid <= 1'b1;
        end else if (tx_accept) begin
            ser_frame <= ser_frame << 8;
            ser_idx   <= ser_idx + 1'b1;
            if (last_byte) begin
                ser_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_debug_frame_collector.sv
// tb/tb_debug_frame_collector.sv - directed self-checking bench for debug_frame_collector
module tb_debug_frame_collector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [5:0]  cmd_id;
    logic [5:0]  select;
    logic [31:0] frame;
    logic        writing;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  frame_count;
    logic        overflow;
    logic        timeout;

    int checks = 0;
    int passes = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    debug_frame_collector #(
        .NB_CONTROL_FRAME(32),
        .NB_SELECT(6),
        .FIFO_DEPTH(4),
        .NB_TIMEOUT(10),
        .TIMEOUT(16)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_cmd_valid(cmd_valid),
        .i_cmd_id(cmd_id),
        .o_request_select(select),
        .i_frame(frame),
        .i_writing(writing),
        .o_tx_data(tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_busy(busy),
        .o_frame_count(frame_count),
        .o_overflow(overflow),
        .o_timeout(timeout)
    );

    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) rx_q.push_back(tx_data);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [5:0] id);
        cmd_valid = 1'b1;
        cmd_id    = id;
        tick();
        cmd_valid = 1'b0;
        cmd_id    = '0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        else passes++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0; frame = '0; writing = 1'b0; tx_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({select, tx_valid, tx_data, busy, frame_count, overflow, timeout} !== 26'd0)
            $display("FAIL reset_outputs: got sel=%h v=%b d=%h busy=%b cnt=%0d ovf=%b to=%b, required all 0",
                     select, tx_valid, tx_data, busy, frame_count, overflow, timeout);
        else passes++;
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b required 0", busy);
        else passes++;
    endtask

    task automatic test_basic;
        logic v0, v1;
        int bad = 0;
        rx_q.delete();
        tx_ready = 1'b1;
        send_cmd(6'd1);
        checks++;
        if (select !== 6'd1 || busy !== 1'b1) $display("FAIL basic_request: sel=%h busy=%b, required 01/1", select, busy);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            writing = 1'b1; frame = 32'hAAAAAAAA;
            tick();
            if (i == 0) v0 = tx_valid;
            if (i == 1) v1 = tx_valid;
        end
        writing = 1'b0;
        wait_idle(100);
        checks++;
        if ({v0, v1} !== 2'b01) $display("FAIL basic_latency: valid after capture edges=%b%b, required 01", v0, v1);
        else passes++;
        checks++;
        if (rx_q.size() != 12) $display("FAIL basic_byte_count: got %0d bytes, required 12", rx_q.size());
        else passes++;
        foreach (rx_q[i]) if (rx_q[i] !== 8'hAA) bad++;
        checks++;
        if (bad != 0) $display("FAIL basic_bytes: %0d bytes differ from AA, required 0", bad);
        else passes++;
        checks++;
        if (frame_count !== 8'd3 || overflow !== 1'b0 || select !== 6'd0)
            $display("FAIL basic_status: cnt=%0d ovf=%b sel=%h, required 3/0/00", frame_count, overflow, select);
        else passes++;
    endtask

    task automatic test_order;
        logic [31:0] tail;
        int bad = 0;
        rx_q.delete();
        tx_ready = 1'b1;
        send_cmd(6'd3);
        checks++;
        if (select !== 6'd3) $display("FAIL order_select: got %h required 03", select);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            writing = 1'b1;
            frame = (i < 5) ? 32'hCCCCCCCC : 32'h11223344;
            tick();
        end
        writing = 1'b0;
        wait_idle(100);
        checks++;
        if (rx_q.size() != 24) $display("FAIL order_byte_count: got %0d bytes, required 24", rx_q.size());
        else passes++;
        tail = '0;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (i < 20 && rx_q[i] !== 8'hCC) bad++;
            if (i >= 20) tail = {tail[23:0], rx_q[i]};
        end
        checks++;
        if (bad != 0) $display("FAIL order_head_bytes: %0d bytes differ from CC, required 0", bad);
        else passes++;
        checks++;
        if (tail !== 32'h11223344) $display("FAIL order_tail: got %h required 11223344", tail);
        else passes++;
        checks++;
        if (frame_count !== 8'd6 || overflow !== 1'b0) $display("FAIL order_status: cnt=%0d ovf=%b, required 6/0", frame_count, overflow);
        else passes++;
    endtask

    task automatic test_overflow;
        logic [31:0] f;
        logic [7:0]  exp;
        int bad = 0;
        rx_q.delete();
        tx_ready = 1'b0;
        send_cmd(6'd4);
        for (int k = 0; k < 6; k++) begin
            writing = 1'b1; frame = 32'hA0B0C0D0 + 32'(k);
            tick();
        end
        writing = 1'b0;
        tick();
        checks++;
        if (frame_count !== 8'd5 || overflow !== 1'b1) $display("FAIL ovf_status: cnt=%0d ovf=%b, required 5/1", frame_count, overflow);
        else passes++;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA0 || busy !== 1'b1)
            $display("FAIL ovf_hold: valid=%b data=%h busy=%b, required 1/A0/1", tx_valid, tx_data, busy);
        else passes++;
        checks++;
        if (rx_q.size() != 0) $display("FAIL ovf_no_transfer: got %0d bytes, required 0", rx_q.size());
        else passes++;
        tx_ready = 1'b1;
        wait_idle(200);
        checks++;
        if (rx_q.size() != 20) $display("FAIL ovf_byte_count: got %0d bytes, required 20", rx_q.size());
        else passes++;
        for (int i = 0; i < rx_q.size() && i < 20; i++) begin
            f = 32'hA0B0C0D0 + 32'(i / 4);
            exp = f[31 - 8 * (i % 4) -: 8];
            if (rx_q[i] !== exp) bad++;
        end
        checks++;
        if (bad != 0 || overflow !== 1'b1) $display("FAIL ovf_bytes: %0d wrong bytes, ovf=%b, required 0/1", bad, overflow);
        else passes++;
    endtask

    task automatic test_timeout;
        logic early = 1'b0;
        rx_q.delete();
        tx_ready = 1'b1;
        send_cmd(6'd2);
        checks++;
        if (select !== 6'd2 || busy !== 1'b1) $display("FAIL to_request: sel=%h busy=%b, required 02/1", select, busy);
        else passes++;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (timeout !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0 || busy !== 1'b1) $display("FAIL to_early: early=%b busy=%b, required 0/1", early, busy);
        else passes++;
        tick();
        checks++;
        if (timeout !== 1'b1 || select !== 6'd0 || busy !== 1'b0)
            $display("FAIL to_pulse: to=%b sel=%h busy=%b, required 1/00/0", timeout, select, busy);
        else passes++;
        tick();
        checks++;
        if (timeout !== 1'b0 || rx_q.size() != 0) $display("FAIL to_single: to=%b bytes=%0d, required 0/0", timeout, rx_q.size());
        else passes++;
    endtask

    task automatic test_back_to_back;
        logic        pv, pr;
        logic [7:0]  pd;
        logic [5:0]  sel_seen = '0;
        logic [63:0] got = '0;
        int viol = 0;
        rx_q.delete();
        tx_ready = 1'b1;
        send_cmd(6'd5);
        for (int c = 0; c < 100; c++) begin
            writing   = (c < 2);
            frame     = (c == 0) ? 32'h01020304 : 32'h05060708;
            cmd_valid = (c == 1 || c == 8);
            cmd_id    = 6'd7;
            tx_ready  = (c % 2 == 0);
            pv = tx_valid; pd = tx_data; pr = tx_ready;
            tick();
            if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) viol++;
            if (c == 1) sel_seen = select;
            if (c > 3 && !busy) break;
        end
        cmd_valid = 1'b0; cmd_id = '0; tx_ready = 1'b1;
        checks++;
        if (viol != 0) $display("FAIL b2b_stable: %0d held bytes changed, required 0", viol);
        else passes++;
        checks++;
        if (sel_seen !== 6'd5) $display("FAIL b2b_ignore_cmd: sel=%h required 05", sel_seen);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL b2b_idle: busy=%b required 0", busy);
        else passes++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) got = {got[55:0], rx_q[i]};
        checks++;
        if (rx_q.size() != 8 || got !== 64'h0102030405060708)
            $display("FAIL b2b_bytes: count=%0d data=%h, required 8/0102030405060708", rx_q.size(), got);
        else passes++;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || select !== 6'd0) $display("FAIL b2b_not_queued: busy=%b sel=%h, required 0/00", busy, select);
        else passes++;
    endtask

    task automatic test_reset_abort;
        logic [31:0] got = '0;
        rx_q.delete();
        tx_ready = 1'b0;
        send_cmd(6'd1);
        writing = 1'b1; frame = 32'h11111111; tick();
        frame = 32'h22222222; tick();
        frame = 32'h33333333;
        checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1) $display("FAIL abort_pre: valid=%b busy=%b, required 1/1", tx_valid, busy);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({select, tx_valid, tx_data, busy, frame_count, overflow, timeout} !== 26'd0)
            $display("FAIL abort_async: sel=%h v=%b d=%h busy=%b cnt=%0d ovf=%b to=%b, required all 0",
                     select, tx_valid, tx_data, busy, frame_count, overflow, timeout);
        else passes++;
        writing = 1'b0;
        tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        rx_q.delete();
        send_cmd(6'd1);
        checks++;
        if (select !== 6'd1 || frame_count !== 8'd0) $display("FAIL abort_restart: sel=%h cnt=%0d, required 01/0", select, frame_count);
        else passes++;
        writing = 1'b1; frame = 32'hDEADBEEF; tick();
        writing = 1'b0;
        wait_idle(100);
        for (int i = 0; i < rx_q.size() && i < 4; i++) got = {got[23:0], rx_q[i]};
        checks++;
        if (frame_count !== 8'd1 || rx_q.size() != 4 || got !== 32'hDEADBEEF)
            $display("FAIL abort_new_cmd: cnt=%0d bytes=%0d data=%h, required 1/4/DEADBEEF", frame_count, rx_q.size(), got);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
